// File: rtl/regfile_write_decoder.sv
// -----------------------------------------------------------------------------
// regfile_write_decoder
// Write side of the 32 x DATA_W register file. A 5-to-32 decoder qualifies the
// write request, a single pending stage holds the write for one cycle and then
// commits it into the register array. Register ZERO_REG (XZR) reads as zero and
// silently drops writes.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : the pending write is visible on regs[pend_addr] (write-through)
//   undefined : regs shows only committed array contents
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   wr_en       in   write request this cycle
//   wr_addr     in   destination register index
//   wr_data     in   write data
//   regs        out  full register array as seen by the read-port muxes
//   pend_valid  out  a write is held in the pending stage
//   pend_addr   out  destination of the pending write
// -----------------------------------------------------------------------------
module regfile_write_decoder #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] regs [0:31],
   output logic              pend_valid,
   output logic [4:0]        pend_addr
);

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_e;

   state_e              state_q,     state_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0]   pend_data_q, pend_data_d;
   logic [NUM_REGS-1:0] row_en_c;
   logic                req_c;
   logic                commit_c;

   // Row decoder; the zero register never gets an enable
   always_comb begin
      row_en_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         row_en_c[i] = wr_en && (wr_addr == ADDR_W'(i)) && (i != ZERO_REG);
      end
   end

   assign req_c = |row_en_c;

   // Pending-stage state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pend_addr_q <= '0;
         pend_data_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
      end
   end

   // Pending-stage next state: a held write always commits on the next edge
   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      commit_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               state_d     = ST_HELD;
               pend_addr_d = wr_addr;
               pend_data_d = wr_data;
            end
         end
         ST_HELD: begin
            commit_c = 1'b1;
            if (req_c) begin
               state_d     = ST_HELD;
               pend_addr_d = wr_addr;
               pend_data_d = wr_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pend_valid = (state_q == ST_HELD);
   assign pend_addr  = pend_addr_q;

   // Register array; the zero row has no storage
   for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_row
      if (g == int'(ZERO_REG)) begin : g_zero
         assign regs[g] = '0;
      end else begin : g_store
         logic [DATA_W-1:0] row_q;
         logic              hit_c;

         assign hit_c = (pend_addr_q == ADDR_W'(g));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               row_q <= '0;
            end else if (commit_c && hit_c) begin
               row_q <= pend_data_q;
            end
         end

`ifdef REGFILE_BYPASS_EN
         // Write-through: the held value shadows the stale row
         assign regs[g] = (pend_valid && hit_c) ? pend_data_q : row_q;
`else
         assign regs[g] = row_q;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_decoder.sv
module tb_regfile_write_decoder;

   localparam int unsigned DW = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] regs [0:31];
   logic          pend_valid;
   logic [4:0]    pend_addr;

   int tests = 0;
   int fails = 0;

   // Behavioural model: committed contents plus at most one held write
   logic [DW-1:0] m_mem [32];
   bit            m_pv;
   logic [4:0]    m_pa;
   logic [DW-1:0] m_pd;
   bit            chk_en = 1'b0;

   regfile_write_decoder #(.DATA_W(DW), .ZERO_REG(31)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .regs       (regs),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_reg(input int i);
      if (i == 31) return '0;
`ifdef REGFILE_BYPASS_EN
      if (m_pv && (int'(m_pa) == i)) return m_pd;
`endif
      return m_mem[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_pv = 1'b0;
      m_pa = '0;
      m_pd = '0;
   endtask

   // Applies the effect of one rising edge using the inputs present at it
   task automatic model_edge();
      if (!reset_n) return;
      if (m_pv) m_mem[m_pa] = m_pd;
      if (wr_en && (wr_addr != 5'd31)) begin
         m_pv = 1'b1;
         m_pa = wr_addr;
         m_pd = wr_data;
      end else begin
         m_pv = 1'b0;
      end
   endtask

   // Drive at the falling edge, take one rising edge, return at next falling edge
   task automatic step(input logic en, input logic [4:0] addr, input logic [DW-1:0] data);
      wr_en   = en;
      wr_addr = addr;
      wr_data = data;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Continuous compare against the model on every falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 32; i++) chk($sformatf("regs[%0d]", i), regs[i], exp_reg(i));
         chk("pend_valid", DW'(pend_valid), DW'(m_pv));
         if (m_pv) chk("pend_addr", DW'(pend_addr), DW'(m_pa));
      end
   end

   initial begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      reset_n = 1'b1;
      model_reset();
      #1 reset_n = 1'b0;
      #2;
      for (int i = 0; i < 32; i++) chk($sformatf("por_regs[%0d]", i), regs[i], '0);
      chk("por_pend_valid", DW'(pend_valid), '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Load X5, then leave a write to X6 pending and reset mid-cycle
      step(1'b1, 5'd5, 64'hDEAD_BEEF);
      step(1'b0, 5'd0, '0);
      chk("x5_loaded", regs[5], 64'hDEAD_BEEF);
      step(1'b1, 5'd6, 64'h6666);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_x5_cleared", regs[5], '0);
      chk("rst_pend_valid", DW'(pend_valid), '0);
      for (int i = 0; i < 32; i++) chk($sformatf("rst_regs[%0d]", i), regs[i], '0);
      @(negedge clk);
      step(1'b1, 5'd9, 64'h9999);     // ignored while in reset
      reset_n = 1'b1;

      // Single write to X3
      step(1'b1, 5'd3, 64'h0123_4567_89AB_CDEF);
      chk("x3_pend_valid", DW'(pend_valid), 64'd1);
      chk("x3_pend_addr", DW'(pend_addr), 64'd3);
`ifdef REGFILE_BYPASS_EN
      chk("x3_after_N", regs[3], 64'h0123_4567_89AB_CDEF);
`else
      chk("x3_after_N", regs[3], '0);
`endif
      step(1'b0, 5'd0, '0);
      chk("x3_after_N1", regs[3], 64'h0123_4567_89AB_CDEF);
      chk("x3_drained", DW'(pend_valid), '0);

      // XZR write is dropped
      step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("xzr_pend_valid", DW'(pend_valid), '0);
      chk("xzr_reads_zero", regs[31], '0);
      step(1'b0, 5'd0, '0);
      chk("xzr_reads_zero2", regs[31], '0);

      // Back-to-back writes to X7
      step(1'b1, 5'd7, 64'h11);
`ifdef REGFILE_BYPASS_EN
      chk("x7_edge1", regs[7], 64'h11);
`else
      chk("x7_edge1", regs[7], '0);
`endif
      step(1'b1, 5'd7, 64'h22);
`ifdef REGFILE_BYPASS_EN
      chk("x7_edge2", regs[7], 64'h22);
`else
      chk("x7_edge2", regs[7], 64'h11);
`endif
      step(1'b0, 5'd0, '0);
      chk("x7_edge3", regs[7], 64'h22);

      // Disabled request with live-looking address/data
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 5'd4, 64'hAA);
         chk("wr_en0_pend_valid", DW'(pend_valid), '0);
         chk("wr_en0_x4", regs[4], '0);
      end

      // Sweep all writable rows on consecutive edges
      for (int i = 0; i < 31; i++) step(1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101);
      step(1'b0, 5'd0, '0);
      step(1'b0, 5'd0, '0);
      for (int i = 0; i < 31; i++)
         chk($sformatf("sweep_x%0d", i), regs[i], 64'(i) * 64'h0101_0101_0101_0101);
      chk("sweep_x31", regs[31], '0);

      // Randomized traffic, biased toward a few addresses to force collisions
      for (int k = 0; k < 400; k++) begin
         logic [4:0] a;
         a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(29, 31)) : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 3) != 0), a, {$urandom, $urandom});
      end
      step(1'b0, 5'd0, '0);
      step(1'b0, 5'd0, '0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
